// File: rtl/vec_mag_pkg.sv
// Shared types and width helpers for the vector magnitude block.
// No logic; compile-time only.
// Not applicable (no handshake).
package vec_mag_pkg;

  // Largest axis count the datapath is sized for; sets the axis counter width.
  localparam int MAX_AXES = 4;

  typedef enum logic [1:0] {
    IDLE,
    SQUARE,
    ROOT,
    DONE
  } state_t;

  // Sum-of-squares width: two products' worth plus growth for the axis count,
  // rounded up to even so the root splits cleanly into SUM_W/2 bits.
  function automatic int sum_w(input int in_w, input int n);
    int s;
    s = 2 * in_w + $clog2(n);
    if ((s % 2) != 0) s = s + 1;
    return s;
  endfunction

  function automatic int out_w(input int in_w, input int n);
    return sum_w(in_w, n) / 2;
  endfunction

endpackage

// File: rtl/isqrt_iter.sv
// Sequential restoring integer square root: root = floor(sqrt(radicand)), rem = radicand - root^2.
// Latency: load edge, then SUM_W/2 iteration edges; done pulses for one cycle after the last.
// No backpressure: load restarts the core unconditionally; results hold until the next load.
module isqrt_iter #(
  parameter  int SUM_W = 34,
  localparam int OUT_W = SUM_W / 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic [SUM_W-1:0] radicand,
  output logic             busy,
  output logic             done,
  output logic [OUT_W-1:0] root,
  output logic [OUT_W:0]   rem
);

  localparam int CW = $clog2(OUT_W + 1);

  logic [SUM_W-1:0] x_q;
  logic [OUT_W:0]   rem_q;
  logic [OUT_W-1:0] root_q;
  logic [CW-1:0]    cnt_q;

  logic [OUT_W+2:0] rem_sh;
  logic [OUT_W+2:0] trial;
  logic             ge;
  logic [OUT_W:0]   rem_nx;
  logic [OUT_W-1:0] root_nx;

  // One root digit: bring down the next two radicand bits and try 4r+1.
  // The partial remainder never exceeds twice the partial root, so OUT_W+1 bits hold it.
  always_comb begin
    rem_sh  = {rem_q, x_q[SUM_W-1 -: 2]};
    trial   = {1'b0, root_q, 2'b01};
    ge      = (rem_sh >= trial);
    rem_nx  = ge ? (OUT_W + 1)'(rem_sh - trial) : (OUT_W + 1)'(rem_sh);
    root_nx = {root_q[OUT_W-2:0], ge};
  end

  // Iteration state: load seeds the radicand, then one bit per cycle MSB first.
  always_ff @(posedge clk) begin
    if (reset) begin
      x_q    <= '0;
      rem_q  <= '0;
      root_q <= '0;
      cnt_q  <= '0;
      done   <= 1'b0;
    end else begin
      done <= 1'b0;
      if (load) begin
        x_q    <= radicand;
        rem_q  <= '0;
        root_q <= '0;
        cnt_q  <= CW'(OUT_W);
      end else if (cnt_q != '0) begin
        x_q    <= x_q << 2;
        rem_q  <= rem_nx;
        root_q <= root_nx;
        cnt_q  <= cnt_q - CW'(1);
        if (cnt_q == CW'(1)) done <= 1'b1;
      end
    end
  end

  assign busy = (cnt_q != '0);
  assign root = root_q;
  assign rem  = rem_q;

endmodule

// File: rtl/vec_magnitude_sqrt.sv
// Euclidean magnitude of one N_AXES signed sample, plus the exact sum of squares.
// Latency: accept at edge k -> out_valid after edge k+N_AXES+OUT_W+1 (21 at defaults).
// Backpressure: one sample in flight; in_ready only in IDLE, result held in DONE until out_ready.
module vec_magnitude_sqrt
  import vec_mag_pkg::*;
#(
  parameter  int IN_W   = 16,
  parameter  int N_AXES = 3,
  parameter  int ROUND  = 0,
  localparam int SUM_W  = sum_w(IN_W, N_AXES),
  localparam int OUT_W  = out_w(IN_W, N_AXES)
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [N_AXES*IN_W-1:0] in_data,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [OUT_W-1:0]       mag_out,
  output logic [SUM_W-1:0]       sumsq_out
);

  localparam int AXW = $clog2(MAX_AXES);

  state_t                  state;
  logic [N_AXES*IN_W-1:0]  data_q;
  logic [AXW-1:0]          axis_idx;
  logic [SUM_W-1:0]        acc;

  logic signed [IN_W-1:0]   axis;
  logic signed [2*IN_W-1:0] sq;
  logic [SUM_W-1:0]         acc_next;
  logic                     last_axis;
  logic                     root_load;
  logic                     root_busy;
  logic                     root_done;
  logic [OUT_W-1:0]         root_val;
  logic [OUT_W:0]           rem_val;
  logic [OUT_W:0]           root_inc;
  logic [OUT_W-1:0]         mag_rounded;

  // Shared multiplier always squares the lowest axis; data_q shifts down one axis per cycle.
  // A square is never negative, so zero-extending it into the accumulator is exact.
  assign axis      = data_q[IN_W-1:0];
  assign sq        = axis * axis;
  assign acc_next  = acc + SUM_W'($unsigned(sq));
  assign last_axis = (axis_idx == AXW'(N_AXES - 1));

  // Start the root core on the final accumulate using the completed sum directly,
  // which saves a cycle versus loading from acc afterwards.
  assign root_load = (state == SQUARE) && last_axis;

  isqrt_iter #(
    .SUM_W(SUM_W)
  ) u_root (
    .clk      (clk),
    .reset    (reset),
    .load     (root_load),
    .radicand (acc_next),
    .busy     (root_busy),
    .done     (root_done),
    .root     (root_val),
    .rem      (rem_val)
  );

  // Round to nearest when the remainder exceeds the root (S > r^2 + r); saturate on wrap.
  always_comb begin
    root_inc    = {1'b0, root_val} + (OUT_W + 1)'(1);
    mag_rounded = root_val;
    if ((ROUND != 0) && (rem_val > {1'b0, root_val})) begin
      mag_rounded = root_inc[OUT_W] ? '1 : root_inc[OUT_W-1:0];
    end
  end

  // Control FSM with registered handshake and result outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      mag_out   <= '0;
      sumsq_out <= '0;
      data_q    <= '0;
      axis_idx  <= '0;
      acc       <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            data_q   <= in_data;
            axis_idx <= '0;
            acc      <= '0;
            in_ready <= 1'b0;
            state    <= SQUARE;
          end
        end
        SQUARE: begin
          acc      <= acc_next;
          data_q   <= data_q >> IN_W;
          axis_idx <= axis_idx + AXW'(1);
          if (last_axis) state <= ROOT;
        end
        ROOT: begin
          // done only means something once the core has stopped iterating
          if (root_done && !root_busy) begin
            mag_out   <= mag_rounded;
            sumsq_out <= acc;
            out_valid <= 1'b1;
            state     <= DONE;
          end
        end
        DONE: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
